// File: rtl/pet_keyboard_if.sv
// -----------------------------------------------------------------------------
// pet_keyboard_if
//
// Pipelined Wishbone slave bundle used by the PET keyboard matrix block.
// Signal names keep their bus-side suffixes (_i into the slave, _o out of it)
// so waveforms line up with the rest of the SoC's Wishbone fabric.
//
//   wb_addr_i    4  row index (already decoded by the address map)
//   wb_data_i    8  write data
//   wb_data_o    8  registered read data
//   wb_we_i      1  write enable
//   wb_cycle_i   1  bus cycle
//   wb_strobe_i  1  strobe
//   wb_sel_i     1  byte select; writes land only when high
//   wb_stall_o   1  never asserted
//   wb_ack_o     1  single-cycle acknowledge
//
// Modports:
//   master - the host / interconnect side
//   slave  - the keyboard block
// -----------------------------------------------------------------------------
interface pet_keyboard_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] wb_addr_i;
  logic [DATA_WIDTH-1:0] wb_data_i;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic                  wb_we_i;
  logic                  wb_cycle_i;
  logic                  wb_strobe_i;
  logic                  wb_sel_i;
  logic                  wb_stall_o;
  logic                  wb_ack_o;

  modport master (
    output wb_addr_i,
    output wb_data_i,
    output wb_we_i,
    output wb_cycle_i,
    output wb_strobe_i,
    output wb_sel_i,
    input  wb_data_o,
    input  wb_stall_o,
    input  wb_ack_o
  );

  modport slave (
    input  wb_addr_i,
    input  wb_data_i,
    input  wb_we_i,
    input  wb_cycle_i,
    input  wb_strobe_i,
    input  wb_sel_i,
    output wb_data_o,
    output wb_stall_o,
    output wb_ack_o
  );
endinterface : pet_keyboard_if

// File: rtl/pet_keyboard.sv
// -----------------------------------------------------------------------------
// pet_keyboard
//
// Keyboard matrix emulation for the PET clone. One key-state byte per matrix
// row is held here; the host fills them in over Wishbone, and the 6502 reads
// them back through snooped PIA1 accesses exactly as it would scan a real
// PET keyboard: write the row number to port A, read the column bits from
// port B. A pressed key reads as 0, so the idle (reset) value of every row
// is all ones.
//
// Ports:
//   wb_clock_i   in   system clock, everything on its rising edge
//   wb_reset_i   in   asynchronous active-high reset
//   wb           slave Wishbone bundle (see pet_keyboard_if)
//   cpu_data_i   in   CPU data bus, used for the row-select write
//   cpu_data_o   out  selected row's byte, presented on a port B read
//   cpu_data_oe  out  drive enable for cpu_data_o
//   cpu_we_i     in   CPU write (1) / read (0)
//   pia1_cs_i    in   PIA1 chip select
//   pia1_rs_i    in   PIA register select (0 = port A, 2 = port B)
// -----------------------------------------------------------------------------
module pet_keyboard #(
  parameter int ROW_COUNT  = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_i,
  pet_keyboard_if.slave         wb,
  input  logic [DATA_WIDTH-1:0] cpu_data_i,
  output logic [DATA_WIDTH-1:0] cpu_data_o,
  output logic                  cpu_data_oe,
  input  logic                  cpu_we_i,
  input  logic                  pia1_cs_i,
  input  logic [1:0]            pia1_rs_i
);

  localparam logic [1:0] PIA_PORTA = 2'd0;
  localparam logic [1:0] PIA_PORTB = 2'd2;
  localparam int         SEL_WIDTH = 4;

  // Unused rows and unused matrix lines read as "no key pressed".
  localparam logic [DATA_WIDTH-1:0] ALL_RELEASED = {DATA_WIDTH{1'b1}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Rows are plain flops rather than a RAM: they need a reset value and a
  // combinational read port towards the CPU.
  logic [DATA_WIDTH-1:0] row_q [ROW_COUNT];
  logic [DATA_WIDTH-1:0] row_d [ROW_COUNT];

  logic [SEL_WIDTH-1:0]  sel_q;
  logic [SEL_WIDTH-1:0]  sel_d;

  logic                  ack_q;
  logic                  ack_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  // ---------------------------------------------------------------------------
  // Wishbone decode
  // ---------------------------------------------------------------------------
  logic wb_accept;
  logic wb_addr_valid;
  logic wb_row_write;

  // Stall is never raised, so every cycle&strobe edge is an accepted beat.
  assign wb_accept     = wb.wb_cycle_i & wb.wb_strobe_i;
  assign wb_addr_valid = (wb.wb_addr_i < SEL_WIDTH'(ROW_COUNT));
  // Out-of-range addresses and sel_i=0 writes are still acknowledged, they
  // just don't touch storage.
  assign wb_row_write  = wb_accept & wb.wb_we_i & wb.wb_sel_i & wb_addr_valid;

  // Per-row write-enable and next-state mux.
  for (genvar gi = 0; gi < ROW_COUNT; gi++) begin : g_row
    assign row_d[gi] = (wb_row_write && (wb.wb_addr_i == SEL_WIDTH'(gi)))
                     ? wb.wb_data_i
                     : row_q[gi];
  end

  // Read mux for the Wishbone side. Uses the current (pre-edge) row values,
  // so a read never observes a write accepted on the same edge.
  logic [DATA_WIDTH-1:0] wb_rd_val;

  always_comb begin
    wb_rd_val = ALL_RELEASED;
    for (int i = 0; i < ROW_COUNT; i++) begin
      if (wb.wb_addr_i == SEL_WIDTH'(i)) begin
        wb_rd_val = row_q[i];
      end
    end
  end

  always_comb begin
    ack_d   = wb_accept;
    // Read data is only refreshed on read beats; writes leave the last read
    // value on the bus.
    rdata_d = rdata_q;
    if (wb_accept && !wb.wb_we_i) begin
      rdata_d = wb_rd_val;
    end
  end

  // ---------------------------------------------------------------------------
  // CPU-side snoop of PIA1
  // ---------------------------------------------------------------------------
  logic cpu_row_select;

  // Only the low nibble of the port A write is the row number; the upper
  // bits drive other PET functions we don't model here. DDR/CR state is
  // ignored: any port A write counts as a row select.
  assign cpu_row_select = pia1_cs_i & cpu_we_i & (pia1_rs_i == PIA_PORTA);

  always_comb begin
    sel_d = sel_q;
    if (cpu_row_select) begin
      sel_d = cpu_data_i[SEL_WIDTH-1:0];
    end
  end

  // Port B read response is combinational from the registers so the CPU
  // gets its data within the same bus cycle.
  always_comb begin
    cpu_data_o = ALL_RELEASED;
    for (int i = 0; i < ROW_COUNT; i++) begin
      if (sel_q == SEL_WIDTH'(i)) begin
        cpu_data_o = row_q[i];
      end
    end
  end

  assign cpu_data_oe = pia1_cs_i & ~cpu_we_i & (pia1_rs_i == PIA_PORTB);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Reset is asynchronous so an in-flight ack is dropped without waiting for
  // a clock edge.
  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      for (int i = 0; i < ROW_COUNT; i++) begin
        row_q[i] <= ALL_RELEASED;
      end
      sel_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      for (int i = 0; i < ROW_COUNT; i++) begin
        row_q[i] <= row_d[i];
      end
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_data_o  = rdata_q;
  assign wb.wb_stall_o = 1'b0;

endmodule : pet_keyboard

// File: tb/tb_pet_keyboard.sv
// -----------------------------------------------------------------------------
// tb_pet_keyboard
//
// Directed bench for pet_keyboard. A behavioural model of the key matrix
// (row array, selected row, expected ack/read data) tracks every clock edge;
// a monitor compares the DUT against it on every falling edge. Directed
// sequences add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_pet_keyboard;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pet_keyboard_if kbd_if ();

  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       cpu_oe;
  logic       cpu_we;
  logic       cs;
  logic [1:0] rs;

  pet_keyboard dut (
    .wb_clock_i  (clk),
    .wb_reset_i  (rst),
    .wb          (kbd_if),
    .cpu_data_i  (cpu_din),
    .cpu_data_o  (cpu_dout),
    .cpu_data_oe (cpu_oe),
    .cpu_we_i    (cpu_we),
    .pia1_cs_i   (cs),
    .pia1_rs_i   (rs)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a 10-entry key matrix plus the CPU's selected row.
  // ---------------------------------------------------------------------------
  logic [7:0] m_row [10];
  logic [3:0] m_sel;
  logic       m_ack;
  logic       m_rd;
  logic [7:0] m_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) m_row[i] = 8'hFF;
      m_sel   = 4'd0;
      m_ack   = 1'b0;
      m_rd    = 1'b0;
      m_rdata = 8'h00;
    end else begin
      m_ack = kbd_if.wb_cycle_i && kbd_if.wb_strobe_i;
      m_rd  = m_ack && !kbd_if.wb_we_i;
      if (m_rd)
        m_rdata = (int'(kbd_if.wb_addr_i) < 10) ? m_row[int'(kbd_if.wb_addr_i)] : 8'hFF;
      if (m_ack && kbd_if.wb_we_i && kbd_if.wb_sel_i && int'(kbd_if.wb_addr_i) < 10)
        m_row[int'(kbd_if.wb_addr_i)] = kbd_if.wb_data_i;
      if (cs && cpu_we && rs == 2'd0)
        m_sel = cpu_din[3:0];
    end
  end

  // Monitor: compares DUT outputs against the model each falling edge.
  always @(negedge clk) begin
    check("mon_ack", kbd_if.wb_ack_o, m_ack);
    check("mon_stall", kbd_if.wb_stall_o, 1'b0);
    if (m_rd) check("mon_rdata", kbd_if.wb_data_o, m_rdata);
    check("mon_cpu_data", cpu_dout, (int'(m_sel) < 10) ? m_row[int'(m_sel)] : 8'hFF);
    check("mon_cpu_oe", cpu_oe, cs && !cpu_we && rs == 2'd2);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 2 time units after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic wb_xfer(input logic we, input logic [3:0] addr, input logic [7:0] data,
                         input logic sel, output logic [7:0] rd);
    @(posedge clk); #2;
    kbd_if.wb_cycle_i  = 1'b1;
    kbd_if.wb_strobe_i = 1'b1;
    kbd_if.wb_we_i     = we;
    kbd_if.wb_addr_i   = addr;
    kbd_if.wb_data_i   = data;
    kbd_if.wb_sel_i    = sel;
    @(posedge clk); #2;
    kbd_if.wb_cycle_i  = 1'b0;
    kbd_if.wb_strobe_i = 1'b0;
    kbd_if.wb_we_i     = 1'b0;
    rd = kbd_if.wb_data_o;
    check("wb_ack", kbd_if.wb_ack_o, 1'b1);
  endtask

  task automatic wb_write(input logic [3:0] addr, input logic [7:0] data);
    logic [7:0] unused;
    wb_xfer(1'b1, addr, data, 1'b1, unused);
  endtask

  task automatic wb_read(input logic [3:0] addr, input logic [7:0] exp);
    logic [7:0] rd;
    wb_xfer(1'b0, addr, 8'h00, 1'b1, rd);
    check("wb_read", rd, exp);
  endtask

  task automatic cpu_write(input logic [1:0] reg_sel, input logic [7:0] data);
    @(posedge clk); #2;
    cs = 1'b1; cpu_we = 1'b1; rs = reg_sel; cpu_din = data;
    @(posedge clk); #2;
    cs = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_portb(input logic [7:0] exp);
    @(posedge clk); #2;
    cs = 1'b1; cpu_we = 1'b0; rs = 2'd2;
    #1;
    check("portb_oe", cpu_oe, 1'b1);
    check("portb_data", cpu_dout, exp);
    @(posedge clk); #2;
    cs = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    kbd_if.wb_cycle_i  = 1'b0;
    kbd_if.wb_strobe_i = 1'b0;
    kbd_if.wb_we_i     = 1'b0;
    kbd_if.wb_sel_i    = 1'b1;
    kbd_if.wb_addr_i   = 4'd0;
    kbd_if.wb_data_i   = 8'h00;
    cpu_din = 8'h00; cpu_we = 1'b0; cs = 1'b0; rs = 2'd0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    check("rst_ack", kbd_if.wb_ack_o, 1'b0);
    check("rst_rdata", kbd_if.wb_data_o, 8'h00);
    check("rst_cpu_data", cpu_dout, 8'hFF);

    // All rows idle after reset.
    for (int r = 0; r < 10; r++) wb_read(4'(r), 8'hFF);

    // Fill each row, select it from the CPU, read it both ways.
    for (int r = 0; r < 10; r++) begin
      wb_write(4'(r), {4'h5, 4'(r)});
      cpu_write(2'd0, 8'(r));
      cpu_portb({4'h5, 4'(r)});
      wb_read(4'(r), {4'h5, 4'(r)});
    end

    // Back-to-back read burst over all rows: one ack per beat, no aliasing.
    @(posedge clk); #2;
    for (int r = 0; r <= 10; r++) begin
      if (r < 10) begin
        kbd_if.wb_cycle_i  = 1'b1;
        kbd_if.wb_strobe_i = 1'b1;
        kbd_if.wb_we_i     = 1'b0;
        kbd_if.wb_addr_i   = 4'(r);
      end else begin
        kbd_if.wb_cycle_i  = 1'b0;
        kbd_if.wb_strobe_i = 1'b0;
      end
      if (r > 0) begin
        check("burst_ack", kbd_if.wb_ack_o, 1'b1);
        check("burst_data", kbd_if.wb_data_o, {4'h5, 4'(r - 1)});
      end
      @(posedge clk); #2;
    end

    for (int r = 0; r < 10; r++) wb_write(4'(r), 8'hFF);
    for (int r = 0; r < 10; r++) wb_read(4'(r), 8'hFF);

    // High nibble of the port A write is ignored; rows >= 10 read as FF.
    wb_write(4'd3, 8'hA3);
    cpu_write(2'd0, 8'hF3);
    cpu_portb(8'hA3);
    cpu_write(2'd0, 8'h0C);
    cpu_portb(8'hFF);
    wb_write(4'd12, 8'h00);
    wb_read(4'd12, 8'hFF);
    wb_read(4'd4, 8'hFF);
    wb_read(4'd3, 8'hA3);

    // Port A read is not driven.
    @(posedge clk); #2;
    cs = 1'b1; cpu_we = 1'b0; rs = 2'd0;
    #1 check("porta_read_oe", cpu_oe, 1'b0);
    @(posedge clk); #2; cs = 1'b0;

    // Writes to port B and CRA leave the selection alone.
    cpu_write(2'd0, 8'h03);
    cpu_write(2'd2, 8'h00);
    cpu_write(2'd1, 8'h00);
    cpu_portb(8'hA3);

    // sel_i=0 write: acked but row unchanged.
    begin
      logic [7:0] dummy;
      wb_xfer(1'b1, 4'd3, 8'h00, 1'b0, dummy);
    end
    wb_read(4'd3, 8'hA3);

    // Wishbone write and CPU read of the same row in the same cycle.
    @(posedge clk); #2;
    cs = 1'b1; cpu_we = 1'b0; rs = 2'd2;
    kbd_if.wb_cycle_i = 1'b1; kbd_if.wb_strobe_i = 1'b1; kbd_if.wb_we_i = 1'b1;
    kbd_if.wb_sel_i = 1'b1; kbd_if.wb_addr_i = 4'd3; kbd_if.wb_data_i = 8'h11;
    #1 check("coll_old", cpu_dout, 8'hA3);
    @(posedge clk); #2;
    kbd_if.wb_cycle_i = 1'b0; kbd_if.wb_strobe_i = 1'b0; kbd_if.wb_we_i = 1'b0;
    check("coll_new", cpu_dout, 8'h11);
    cs = 1'b0;

    // CPU select and Wishbone write in the same cycle both take effect.
    @(posedge clk); #2;
    cs = 1'b1; cpu_we = 1'b1; rs = 2'd0; cpu_din = 8'h05;
    kbd_if.wb_cycle_i = 1'b1; kbd_if.wb_strobe_i = 1'b1; kbd_if.wb_we_i = 1'b1;
    kbd_if.wb_addr_i = 4'd5; kbd_if.wb_data_i = 8'h55;
    @(posedge clk); #2;
    cs = 1'b0; cpu_we = 1'b0;
    kbd_if.wb_cycle_i = 1'b0; kbd_if.wb_strobe_i = 1'b0; kbd_if.wb_we_i = 1'b0;
    check("concur_ack", kbd_if.wb_ack_o, 1'b1);
    check("concur_cpu", cpu_dout, 8'h55);

    // Reset while a read is being acknowledged.
    wb_write(4'd0, 8'h42);
    @(posedge clk); #2;
    kbd_if.wb_cycle_i = 1'b1; kbd_if.wb_strobe_i = 1'b1; kbd_if.wb_we_i = 1'b0;
    kbd_if.wb_addr_i = 4'd5;
    @(posedge clk); #1;
    check("pre_rst_ack", kbd_if.wb_ack_o, 1'b1);
    check("pre_rst_rdata", kbd_if.wb_data_o, 8'h55);
    #1 rst = 1'b1;
    #1;
    check("async_rst_ack", kbd_if.wb_ack_o, 1'b0);
    check("async_rst_rdata", kbd_if.wb_data_o, 8'h00);
    check("async_rst_cpu", cpu_dout, 8'hFF);
    kbd_if.wb_cycle_i = 1'b0; kbd_if.wb_strobe_i = 1'b0;
    @(posedge clk); #2 rst = 1'b0;

    for (int r = 0; r < 10; r++) wb_read(4'(r), 8'hFF);
    // Selection returned to row 0.
    wb_write(4'd0, 8'h42);
    #1 check("rst_sel_zero", cpu_dout, 8'h42);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_pet_keyboard
